// File: rtl/tawas_axi_load.sv
// tawas_axi_load: turns load/store requests into single-beat AXI reads and returns
//   extracted, sign/zero-extended data as a one-cycle register-file write.
// Latency: accept at T -> ARVALID at T+1; R handshake at N -> writeback/error pulse at N+1.
// Backpressure: REQ_RDY drops when 4 loads are in flight, when a held AR is not taken,
//   or when the requesting slice already has a load outstanding. Writeback has none.
// Ports:
//   CLK, RST                      clock, synchronous active-high reset
//   REQ_*                         load request (slice, dest register, address, size, signed)
//   SLICE_BUSY                    per-slice load-outstanding flags for the scheduler
//   ARVALID/ARREADY/ARADDR        AXI read address channel (word-aligned, single beat)
//   RVALID/RREADY/RDATA/RRESP     AXI read data channel (in order, no ID)
//   AXI_LOAD_VLD/_SLICE/_SEL/AXI_LOAD  register-file write port
//   LOAD_ERR                      one-cycle pulse for a non-OKAY read response
module tawas_axi_load #(
  parameter int ADDR_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ_VLD,
  output logic              REQ_RDY,
  input  logic [1:0]        REQ_SLICE,
  input  logic [2:0]        REQ_SEL,
  input  logic [ADDR_W-1:0] REQ_ADDR,
  input  logic [1:0]        REQ_SIZE,
  input  logic              REQ_SIGNED,
  output logic [3:0]        SLICE_BUSY,
  output logic              ARVALID,
  input  logic              ARREADY,
  output logic [ADDR_W-1:0] ARADDR,
  input  logic              RVALID,
  output logic              RREADY,
  input  logic [31:0]       RDATA,
  input  logic [1:0]        RRESP,
  output logic              AXI_LOAD_VLD,
  output logic [1:0]        AXI_LOAD_SLICE,
  output logic [2:0]        AXI_LOAD_SEL,
  output logic [31:0]       AXI_LOAD,
  output logic              LOAD_ERR
);

  // Per-load bookkeeping kept until its read data returns.
  typedef struct packed {
    logic [1:0] slice;
    logic [2:0] sel;
    logic [1:0] ofs;
    logic [1:0] size;
    logic       sgn;
  } trk_t;

  trk_t        trk_mem [4];
  logic [1:0]  wr_ptr;
  logic [1:0]  rd_ptr;
  logic [2:0]  count;
  logic [2:0]  count_nxt;
  logic        req_fire;
  logic        r_fire;
  logic        r_ok;
  trk_t        head;
  trk_t        push_ent;
  logic [3:0]  busy_set;
  logic [3:0]  busy_clr;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] ext_data;

  // A held AR that is being taken this cycle frees the address register for a new request.
  assign REQ_RDY  = (count < 3'd4) && (!ARVALID || ARREADY) && !SLICE_BUSY[REQ_SLICE];
  assign RREADY   = (count != 3'd0);
  assign req_fire = REQ_VLD && REQ_RDY;
  assign r_fire   = RVALID && RREADY;
  assign r_ok     = (RRESP == 2'b00);
  assign head     = trk_mem[rd_ptr];

  assign push_ent = '{slice: REQ_SLICE, sel: REQ_SEL, ofs: REQ_ADDR[1:0],
                      size: REQ_SIZE, sgn: REQ_SIGNED};

  // Same-slice set and clear never coincide: a busy slice cannot be accepted.
  assign busy_set = req_fire ? (4'b0001 << REQ_SLICE) : 4'b0000;
  assign busy_clr = r_fire ? (4'b0001 << head.slice) : 4'b0000;

  assign count_nxt = count + {2'b00, req_fire} - {2'b00, r_fire};

  // Lane select and extension; size 3 behaves as a word.
  always_comb begin
    byte_v   = RDATA[{head.ofs, 3'b000} +: 8];
    half_v   = head.ofs[1] ? RDATA[31:16] : RDATA[15:0];
    ext_data = RDATA;
    case (head.size)
      2'd0:    ext_data = {{24{head.sgn & byte_v[7]}}, byte_v};
      2'd1:    ext_data = {{16{head.sgn & half_v[15]}}, half_v};
      default: ext_data = RDATA;
    endcase
  end

  // Tracking storage needs no reset; only valid entries are ever read.
  always_ff @(posedge CLK) begin
    if (req_fire) begin
      trk_mem[wr_ptr] <= push_ent;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      SLICE_BUSY     <= '0;
      ARVALID        <= 1'b0;
      ARADDR         <= '0;
      AXI_LOAD_VLD   <= 1'b0;
      AXI_LOAD_SLICE <= '0;
      AXI_LOAD_SEL   <= '0;
      AXI_LOAD       <= '0;
      LOAD_ERR       <= 1'b0;
    end else begin
      if (req_fire) begin
        ARVALID <= 1'b1;
        ARADDR  <= {REQ_ADDR[ADDR_W-1:2], 2'b00};
        wr_ptr  <= wr_ptr + 2'd1;
      end else if (ARREADY) begin
        ARVALID <= 1'b0;
      end
      if (r_fire) begin
        rd_ptr <= rd_ptr + 2'd1;
      end
      count        <= count_nxt;
      SLICE_BUSY   <= (SLICE_BUSY & ~busy_clr) | busy_set;
      AXI_LOAD_VLD <= r_fire && r_ok;
      LOAD_ERR     <= r_fire && !r_ok;
      if (r_fire && r_ok) begin
        AXI_LOAD_SLICE <= head.slice;
        AXI_LOAD_SEL   <= head.sel;
        AXI_LOAD       <= ext_data;
      end
    end
  end

endmodule

// File: tb/tb_tawas_axi_load.sv
// Bench for tawas_axi_load: random traffic plus directed load scenarios, with a
// queue-based reference of outstanding loads and a writeback scoreboard.
module tb_tawas_axi_load;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        REQ_VLD, REQ_RDY;
  logic [1:0]  REQ_SLICE;
  logic [2:0]  REQ_SEL;
  logic [31:0] REQ_ADDR;
  logic [1:0]  REQ_SIZE;
  logic        REQ_SIGNED;
  logic [3:0]  SLICE_BUSY;
  logic        ARVALID, ARREADY;
  logic [31:0] ARADDR;
  logic        RVALID, RREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        AXI_LOAD_VLD;
  logic [1:0]  AXI_LOAD_SLICE;
  logic [2:0]  AXI_LOAD_SEL;
  logic [31:0] AXI_LOAD;
  logic        LOAD_ERR;

  always #5 CLK = ~CLK;

  tawas_axi_load #(.ADDR_W(32)) dut (
    .CLK(CLK), .RST(RST),
    .REQ_VLD(REQ_VLD), .REQ_RDY(REQ_RDY), .REQ_SLICE(REQ_SLICE), .REQ_SEL(REQ_SEL),
    .REQ_ADDR(REQ_ADDR), .REQ_SIZE(REQ_SIZE), .REQ_SIGNED(REQ_SIGNED),
    .SLICE_BUSY(SLICE_BUSY),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP),
    .AXI_LOAD_VLD(AXI_LOAD_VLD), .AXI_LOAD_SLICE(AXI_LOAD_SLICE),
    .AXI_LOAD_SEL(AXI_LOAD_SEL), .AXI_LOAD(AXI_LOAD), .LOAD_ERR(LOAD_ERR)
  );

  typedef struct {
    logic [1:0] slice;
    logic [2:0] sel;
    logic [1:0] ofs;
    logic [1:0] size;
    logic       sgn;
  } ld_t;

  typedef struct {
    int          due;
    logic        err;
    logic [1:0]  slice;
    logic [2:0]  sel;
    logic [31:0] data;
  } wb_t;

  ld_t         out_q[$];
  logic [31:0] ar_q[$];
  wb_t         wb_q[$];
  int          rd_pending = 0;
  logic [3:0]  m_busy = 4'b0000;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  bit          started = 1'b0;

  wb_t         mon_e;
  logic        mon_rdy;
  ld_t         obs_ld;

  function automatic logic [31:0] ref_load(input logic [31:0] d, input logic [1:0] ofs,
                                           input logic [1:0] size, input logic sgn);
    logic [31:0] v;
    case (size)
      2'd0: begin
        v = (d >> (8 * int'(ofs))) & 32'h0000_00FF;
        if (sgn && v[7]) v = v | 32'hFFFF_FF00;
      end
      2'd1: begin
        v = ofs[1] ? (d >> 16) : (d & 32'h0000_FFFF);
        if (sgn && v[15]) v = v | 32'hFFFF_0000;
      end
      default: v = d;
    endcase
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge CLK) cyc <= cyc + 1;

  // Monitor: compares DUT outputs against the reference state and pops the scoreboard.
  always @(negedge CLK) begin
    if (started) begin
      chk("slice_busy", SLICE_BUSY, m_busy);
      chk("arvalid", ARVALID, ar_q.size() != 0);
      if (ar_q.size() != 0) chk("araddr", ARADDR, ar_q[0]);
      chk("rready", RREADY, out_q.size() != 0);
      mon_rdy = (out_q.size() < 4) && (ar_q.size() == 0 || ARREADY) && !m_busy[REQ_SLICE];
      chk("req_rdy", REQ_RDY, mon_rdy);
      if (wb_q.size() != 0 && wb_q[0].due == cyc) begin
        mon_e = wb_q.pop_front();
        chk("wb_vld", AXI_LOAD_VLD, !mon_e.err);
        chk("load_err", LOAD_ERR, mon_e.err);
        if (!mon_e.err) begin
          chk("wb_slice", AXI_LOAD_SLICE, mon_e.slice);
          chk("wb_sel", AXI_LOAD_SEL, mon_e.sel);
          chk("wb_data", AXI_LOAD, mon_e.data);
        end
      end else begin
        chk("idle_vld", AXI_LOAD_VLD, 1'b0);
        chk("idle_err", LOAD_ERR, 1'b0);
      end
    end
  end

  // Observer: records handshakes about to complete on the next edge into the reference.
  always @(negedge CLK) begin
    #1;
    if (RST) begin
      out_q.delete();
      ar_q.delete();
      wb_q.delete();
      rd_pending = 0;
      m_busy = 4'b0000;
    end else begin
      if (RVALID && RREADY && out_q.size() != 0) begin
        obs_ld = out_q.pop_front();
        if (rd_pending > 0) rd_pending--;
        m_busy[obs_ld.slice] = 1'b0;
        wb_q.push_back('{due: cyc + 1, err: (RRESP != 2'b00), slice: obs_ld.slice,
                         sel: obs_ld.sel,
                         data: ref_load(RDATA, obs_ld.ofs, obs_ld.size, obs_ld.sgn)});
      end
      if (ARVALID && ARREADY && ar_q.size() != 0) begin
        void'(ar_q.pop_front());
        rd_pending++;
      end
      if (REQ_VLD && REQ_RDY) begin
        out_q.push_back('{slice: REQ_SLICE, sel: REQ_SEL, ofs: REQ_ADDR[1:0],
                          size: REQ_SIZE, sgn: REQ_SIGNED});
        ar_q.push_back({REQ_ADDR[31:2], 2'b00});
        m_busy[REQ_SLICE] = 1'b1;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    REQ_VLD = 1'b0;
    ARREADY = 1'b0;
    RVALID  = 1'b0;
    RRESP   = 2'b00;
  endtask

  task automatic set_req(input logic [1:0] sl, input logic [2:0] se, input logic [31:0] ad,
                         input logic [1:0] sz, input logic sg);
    REQ_VLD    = 1'b1;
    REQ_SLICE  = sl;
    REQ_SEL    = se;
    REQ_ADDR   = ad;
    REQ_SIZE   = sz;
    REQ_SIGNED = sg;
  endtask

  task automatic drain();
    int n;
    n = 0;
    REQ_VLD = 1'b0;
    ARREADY = 1'b1;
    RRESP   = 2'b00;
    while ((out_q.size() != 0 || wb_q.size() != 0) && n < 300) begin
      RVALID = (rd_pending > 0);
      RDATA  = $urandom;
      tick();
      n++;
    end
    RVALID  = 1'b0;
    ARREADY = 1'b0;
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL drain: outstanding %0d after %0d cycles, required 0", out_q.size(), n);
    end
    tick();
  endtask

  // One isolated load: request, AR held for ar_wait cycles, then one R beat.
  task automatic single_load(input logic [1:0] sl, input logic [2:0] se, input logic [31:0] ad,
                             input logic [1:0] sz, input logic sg, input logic [31:0] rd,
                             input logic [1:0] rr, input int ar_wait,
                             output logic [31:0] o_data, output logic o_vld, output logic o_err,
                             output logic [3:0] o_busy, output logic [1:0] o_slice,
                             output logic [2:0] o_sel);
    int held;
    idle_inputs();
    set_req(sl, se, ad, sz, sg);
    tick();
    REQ_VLD = 1'b0;
    held = 0;
    for (int i = 0; i < ar_wait; i++) begin
      @(negedge CLK);
      if (ARVALID && ARADDR == {ad[31:2], 2'b00}) held++;
      tick();
    end
    chk("ar_hold", held, ar_wait);
    ARREADY = 1'b1;
    tick();
    ARREADY = 1'b0;
    RVALID  = 1'b1;
    RDATA   = rd;
    RRESP   = rr;
    tick();
    RVALID  = 1'b0;
    RRESP   = 2'b00;
    @(negedge CLK);
    o_data  = AXI_LOAD;
    o_vld   = AXI_LOAD_VLD;
    o_err   = LOAD_ERR;
    o_busy  = SLICE_BUSY;
    o_slice = AXI_LOAD_SLICE;
    o_sel   = AXI_LOAD_SEL;
    tick();
  endtask

  logic [31:0] od;
  logic        ov, oe;
  logic [3:0]  ob;
  logic [1:0]  os;
  logic [2:0]  ose;
  logic [31:0] rv [5];
  logic [1:0]  exp_sl [5];

  initial begin
    idle_inputs();
    REQ_SLICE = 2'd0; REQ_SEL = 3'd0; REQ_ADDR = 32'h0; REQ_SIZE = 2'd0; REQ_SIGNED = 1'b0;
    RDATA = 32'h0;
    RST = 1'b1;
    repeat (2) tick();
    @(negedge CLK);
    chk("rst_busy", SLICE_BUSY, 4'b0000);
    chk("rst_arvalid", ARVALID, 1'b0);
    chk("rst_araddr", ARADDR, 32'h0);
    chk("rst_rready", RREADY, 1'b0);
    chk("rst_vld", AXI_LOAD_VLD, 1'b0);
    chk("rst_slice", AXI_LOAD_SLICE, 2'd0);
    chk("rst_sel", AXI_LOAD_SEL, 3'd0);
    chk("rst_load", AXI_LOAD, 32'h0);
    chk("rst_err", LOAD_ERR, 1'b0);
    chk("rst_req_rdy", REQ_RDY, 1'b1);
    tick();
    RST = 1'b0;
    started = 1'b1;

    // Random traffic.
    repeat (1500) begin
      REQ_VLD    = ($urandom_range(0, 2) != 0);
      REQ_SLICE  = 2'($urandom_range(0, 3));
      REQ_SEL    = 3'($urandom_range(0, 7));
      REQ_ADDR   = $urandom;
      REQ_SIZE   = 2'($urandom_range(0, 3));
      REQ_SIGNED = 1'($urandom_range(0, 1));
      ARREADY    = ($urandom_range(0, 3) != 0);
      RVALID     = (rd_pending > 0) && ($urandom_range(0, 2) != 0);
      RDATA      = $urandom;
      RRESP      = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      tick();
    end
    drain();

    // Word load with AR held two cycles.
    single_load(2'd1, 3'd3, 32'h0000_1004, 2'd2, 1'b0, 32'hDEAD_BEEF, 2'b00, 2,
                od, ov, oe, ob, os, ose);
    chk("word_vld", ov, 1'b1);
    chk("word_slice", os, 2'd1);
    chk("word_sel", ose, 3'd3);
    chk("word_data", od, 32'hDEAD_BEEF);
    chk("word_busy", ob, 4'b0000);

    single_load(2'd0, 3'd5, 32'h0000_1003, 2'd0, 1'b1, 32'h80FF_1234, 2'b00, 0,
                od, ov, oe, ob, os, ose);
    chk("byte_signed", od, 32'hFFFF_FF80);
    single_load(2'd0, 3'd5, 32'h0000_1003, 2'd0, 1'b0, 32'h80FF_1234, 2'b00, 0,
                od, ov, oe, ob, os, ose);
    chk("byte_unsigned", od, 32'h0000_0080);
    single_load(2'd3, 3'd6, 32'h0000_1002, 2'd1, 1'b1, 32'h8001_0000, 2'b00, 1,
                od, ov, oe, ob, os, ose);
    chk("half_signed", od, 32'hFFFF_8001);

    // Error response.
    single_load(2'd2, 3'd1, 32'h0000_2000, 2'd2, 1'b0, 32'h1234_5678, 2'b10, 0,
                od, ov, oe, ob, os, ose);
    chk("err_pulse", oe, 1'b1);
    chk("err_no_vld", ov, 1'b0);
    chk("err_busy", ob, 4'b0000);
    @(negedge CLK);
    chk("err_one_cycle", LOAD_ERR, 1'b0);
    tick();

    // Four slices back to back, then in-order returns with a slice-0 reissue.
    idle_inputs();
    ARREADY = 1'b1;
    for (int k = 0; k < 4; k++) begin
      set_req(2'(k), 3'(k), 32'h0000_3000 + 32'(4 * k), 2'd2, 1'b0);
      tick();
    end
    REQ_VLD = 1'b0;
    @(negedge CLK);
    chk("full_rdy", REQ_RDY, 1'b0);
    chk("full_busy", SLICE_BUSY, 4'b1111);
    tick();
    rv[0] = 32'hAAAA_0001; rv[1] = 32'hBBBB_0002; rv[2] = 32'hCCCC_0003;
    rv[3] = 32'hDDDD_0004; rv[4] = 32'hEEEE_0005;
    exp_sl[0] = 2'd0; exp_sl[1] = 2'd1; exp_sl[2] = 2'd2; exp_sl[3] = 2'd3; exp_sl[4] = 2'd0;
    for (int i = 0; i < 5; i++) begin
      RVALID = 1'b1;
      RDATA  = rv[i];
      if (i == 1) set_req(2'd0, 3'd7, 32'h0000_4000, 2'd2, 1'b0);
      @(negedge CLK);
      if (i == 1) chk("reissue_rdy", REQ_RDY, 1'b1);
      if (i > 0) begin
        chk("order_vld", AXI_LOAD_VLD, 1'b1);
        chk("order_slice", AXI_LOAD_SLICE, exp_sl[i-1]);
        chk("order_data", AXI_LOAD, rv[i-1]);
      end
      tick();
      REQ_VLD = 1'b0;
    end
    RVALID = 1'b0;
    @(negedge CLK);
    chk("reissue_slice", AXI_LOAD_SLICE, 2'd0);
    chk("reissue_sel", AXI_LOAD_SEL, 3'd7);
    chk("reissue_data", AXI_LOAD, rv[4]);
    tick();
    drain();

    // Busy stall on slice 2.
    idle_inputs();
    ARREADY = 1'b1;
    set_req(2'd2, 3'd1, 32'h0000_5000, 2'd2, 1'b0);
    tick();
    set_req(2'd2, 3'd2, 32'h0000_5008, 2'd2, 1'b0);
    repeat (2) begin
      @(negedge CLK);
      chk("stall_rdy", REQ_RDY, 1'b0);
      tick();
    end
    RVALID = 1'b1;
    RDATA  = 32'h5555_AAAA;
    @(negedge CLK);
    chk("stall_rdy_r", REQ_RDY, 1'b0);
    tick();
    RVALID = 1'b0;
    @(negedge CLK);
    chk("stall_release", REQ_RDY, 1'b1);
    chk("stall_busy_clr", SLICE_BUSY, 4'b0000);
    tick();
    REQ_VLD = 1'b0;
    @(negedge CLK);
    chk("stall_busy_set", SLICE_BUSY, 4'b0100);
    tick();
    drain();

    // Reset with three loads outstanding and an AR pending.
    idle_inputs();
    ARREADY = 1'b1;
    set_req(2'd0, 3'd1, 32'h0000_6000, 2'd2, 1'b0); tick();
    set_req(2'd1, 3'd2, 32'h0000_6004, 2'd2, 1'b0); tick();
    set_req(2'd3, 3'd3, 32'h0000_6008, 2'd2, 1'b0); tick();
    REQ_VLD = 1'b0;
    ARREADY = 1'b0;
    @(negedge CLK);
    chk("pre_rst_arvalid", ARVALID, 1'b1);
    tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    @(negedge CLK);
    chk("mid_rst_busy", SLICE_BUSY, 4'b0000);
    chk("mid_rst_arvalid", ARVALID, 1'b0);
    chk("mid_rst_araddr", ARADDR, 32'h0);
    chk("mid_rst_rready", RREADY, 1'b0);
    chk("mid_rst_vld", AXI_LOAD_VLD, 1'b0);
    chk("mid_rst_load", AXI_LOAD, 32'h0);
    chk("mid_rst_slice", AXI_LOAD_SLICE, 2'd0);
    chk("mid_rst_sel", AXI_LOAD_SEL, 3'd0);
    chk("mid_rst_err", LOAD_ERR, 1'b0);
    chk("mid_rst_rdy", REQ_RDY, 1'b1);
    tick();
    RVALID = 1'b1;
    RDATA  = 32'h0BAD_F00D;
    @(negedge CLK);
    chk("post_rst_rready", RREADY, 1'b0);
    tick();
    RVALID = 1'b0;
    @(negedge CLK);
    chk("post_rst_vld", AXI_LOAD_VLD, 1'b0);
    chk("post_rst_err", LOAD_ERR, 1'b0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
